// File: rtl/pipe_ctrl_if.sv
// Request/command bundle between the pipeline stages and the pipeline control unit.
// The stages drive requests through the master modport; the control unit uses the slave modport.
interface pipe_ctrl_if #(
  parameter int N_STAGES = 6,
  parameter int CNT_W    = 32
);
  localparam int SRC_W = $clog2(N_STAGES);

  logic [N_STAGES-1:0] pause_req;
  logic [N_STAGES-1:0] flush_req;
  logic                wdog_clr;
  logic [N_STAGES-1:0] pause;
  logic [N_STAGES-1:0] flush;
  logic [SRC_W-1:0]    stall_src;
  logic                wdog_err;
  logic [CNT_W-1:0]    stall_cnt;
  logic [CNT_W-1:0]    flush_cnt;

  modport master (
    output pause_req, flush_req, wdog_clr,
    input  pause, flush, stall_src, wdog_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  pause_req, flush_req, wdog_clr,
    output pause, flush, stall_src, wdog_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Front-end pipeline control: merges per-stage pause/flush requests into hold/invalidate
// commands, stretches flushes over a hold window, and tracks stalls with a watchdog and counters.
module pipe_ctrl_unit #(
  parameter int N_STAGES   = 6,
  parameter int FLUSH_HOLD = 1,
  parameter int WDOG_W     = 10,
  parameter int CNT_W      = 32
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave ctrl
);
  localparam int SRC_W = $clog2(N_STAGES);
  localparam int HC_W  = 3;
  localparam logic [HC_W-1:0]   HOLD_RELOAD = HC_W'(FLUSH_HOLD - 1);
  localparam logic [WDOG_W-1:0] WD_MAX      = '1;

  typedef enum logic {ST_IDLE, ST_HOLD} hold_st_e;

  hold_st_e            state_q;
  logic [N_STAGES-1:0] hold_mask_q;
  logic [HC_W-1:0]     hold_cnt_q;
  logic [SRC_W-1:0]    src_q;
  logic [WDOG_W-1:0]   wdog_cnt_q;
  logic                wdog_err_q;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic [CNT_W-1:0]    flush_cnt_q;

  logic [N_STAGES-1:0] new_mask;
  logic [N_STAGES-1:0] merged_mask;
  logic [N_STAGES-1:0] flush_w;
  logic [N_STAGES-1:0] pause_raw;
  logic [N_STAGES-1:0] pause_w;
  logic [SRC_W-1:0]    src_d;
  logic                any_flush;
  logic                wdog_run;
  logic                acc;

  always_comb begin
    new_mask = '0;
    // Ascending scan: the highest requesting stage leaves the widest mask.
    for (int k = 0; k < N_STAGES; k++) begin
      if (ctrl.flush_req[k]) new_mask = (N_STAGES'(1) << k) - N_STAGES'(1);
    end
    merged_mask = hold_mask_q | new_mask;
    flush_w     = merged_mask;

    acc = 1'b0;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      acc          = acc | ctrl.pause_req[i];
      pause_raw[i] = acc;
    end
    pause_w = pause_raw & ~flush_w;

    src_d = src_q;
    for (int i = 0; i < N_STAGES; i++) begin
      if (ctrl.pause_req[i]) src_d = SRC_W'(i);
    end

    any_flush = |ctrl.flush_req;
    wdog_run  = pause_w[0] & ~(|flush_w);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_mask_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_flush && (FLUSH_HOLD > 1) && (new_mask != '0)) begin
            hold_mask_q <= new_mask;
            hold_cnt_q  <= HOLD_RELOAD;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (any_flush) begin
            hold_mask_q <= merged_mask;
            hold_cnt_q  <= HOLD_RELOAD;
          end else if (hold_cnt_q <= HC_W'(1)) begin
            hold_mask_q <= '0;
            hold_cnt_q  <= '0;
            state_q     <= ST_IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q - HC_W'(1);
          end
        end
        default: begin
          hold_mask_q <= '0;
          hold_cnt_q  <= '0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q       <= '0;
      wdog_cnt_q  <= '0;
      wdog_err_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      src_q <= src_d;

      // Clear wins over a timeout landing in the same cycle.
      if (ctrl.wdog_clr) begin
        wdog_cnt_q <= '0;
        wdog_err_q <= 1'b0;
      end else if (wdog_run) begin
        if (wdog_cnt_q != WD_MAX) begin
          wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
          if (wdog_cnt_q == WD_MAX - WDOG_W'(1)) wdog_err_q <= 1'b1;
        end
      end else begin
        wdog_cnt_q <= '0;
      end

      if (pause_w[0] && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (any_flush && !(&flush_cnt_q))  flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign ctrl.pause     = pause_w;
  assign ctrl.flush     = flush_w;
  assign ctrl.stall_src = src_q;
  assign ctrl.wdog_err  = wdog_err_q;
  assign ctrl.stall_cnt = stall_cnt_q;
  assign ctrl.flush_cnt = flush_cnt_q;
endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Parametrised front-end pipeline control unit. Merges per-stage pause and flush requests into per-stage pause/flush commands for an N-stage in-order pipeline. Adds held flush windows, a stall watchdog and saturating stall/flush event counters. Stage 0 is the most upstream stage (PC/IF0 regs); stage N_STAGES-1 is the most downstream (instruction buffer).

## Interface
- N_STAGES, 6, number of controlled stages (2..16)
- FLUSH_HOLD, 1, cycles each flush command stays asserted (1..7)
- WDOG_W, 10, watchdog counter width; timeout at 2^WDOG_W-1 consecutive cycles
- CNT_W, 32, width of the event counters

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- pause_req  in  N_STAGES  bit i: stage i cannot accept/advance this cycle
- flush_req  in  N_STAGES  bit k: stage k resolved a redirect; flush everything upstream of k
- wdog_clr  in  1  clears wdog_err and the watchdog counter
- pause  out  N_STAGES  per-stage hold command
- flush  out  N_STAGES  per-stage invalidate command
- stall_src  out  $clog2(N_STAGES)  registered index of furthest-downstream active pause requester
- wdog_err  out  1  sticky watchdog timeout flag
- stall_cnt  out  CNT_W  cycles with pause[0]=1, saturating
- flush_cnt  out  CNT_W  cycles with any flush_req bit set, saturating

## Operation
- Pause merge (combinational): pause[i] = OR of pause_req[j] for j >= i, masked by ~flush[i]. A request holds its own stage and every upstream stage; downstream stages keep flowing.
- Flush mask: for request bit k, new_mask = bits 0..k-1 set (k=0 gives empty mask). Several bits in one cycle: highest k wins (widest mask).
- flush = new_mask OR hold_mask. Flush takes priority over pause in the same stage.
- Flush hold: on any flush_req, hold_mask <= hold_mask OR new_mask, hold_cnt <= FLUSH_HOLD-1. Each cycle with no flush_req and hold_cnt > 0: decrement; when hold_cnt reaches 0 (or FLUSH_HOLD=1) hold_mask <= 0. A new flush during a hold reloads the count and widens the mask (never narrows).
- Hold states: IDLE (hold_cnt=0, hold_mask=0) and HOLD (hold_mask != 0). IDLE->HOLD on flush_req with k>0 and FLUSH_HOLD>1; HOLD->IDLE when the count expires without a new request.
- stall_src: registered each cycle; highest i with pause_req[i]=1; unchanged when no request active.
- Watchdog: counter increments while pause[0]=1 and flush==0, resets to 0 otherwise; on reaching all-ones sets wdog_err and holds count. wdog_clr has priority over a same-cycle timeout.
- Counters: +1 per qualifying cycle, stop at all-ones.

## Timing
- pause, flush: combinational from pause_req/flush_req, zero-cycle latency (same-cycle stall as the existing IF control).
- Flush command visible FLUSH_HOLD cycles total: request cycle plus FLUSH_HOLD-1 registered cycles.
- stall_src, wdog_err, counters: one cycle after the qualifying input.
- Reset values: hold_mask=0, hold_cnt=0, stall_src=0, wdog_err=0, watchdog=0, stall_cnt=0, flush_cnt=0; with inputs low, pause=0, flush=0.
- Reset mid-hold: flush drops immediately (asynchronous), counters cleared; no residual flush after release.
- pause_req and flush_req are sampled every cycle; no handshake, no request latching.

## Test plan
- N=6, pause_req=6'b000100 -> pause=6'b000111, flush=0; next cycle stall_src=2, stall_cnt increments by 1.
- flush_req=6'b010000, FLUSH_HOLD=3 -> flush=6'b001111 for exactly 3 cycles, pause masked to 0 in stages 0..3, flush_cnt=1.
- Same-cycle flush_req=6'b001010 -> flush=6'b000111 (k=3 wins); flush_req bit1 at hold cycle 2 -> mask stays 000111, hold extends to 3 more cycles.
- pause_req[5] held continuously, WDOG_W=4 -> wdog_err rises after 15 cycles, stays set; wdog_clr pulse -> wdog_err=0 next cycle, count restarts.
- stall_cnt preset near all-ones (CNT_W=4, 20 stall cycles) -> saturates at 15, no wrap.
- rst_n low during a 3-cycle flush hold -> flush=0 immediately, all counters 0; after release with idle inputs, outputs stay 0.
